case_5_mul_share_arb: RTL and testbench
=======================================

Name: case_5_mul_share_arb

Overview:
- Time-shares one signed multiplier datapath (8s x 8s -> 8, combinational, HLS `mul_8s_8s_8` style) between NUM_REQ requesters.
- Round-robin arbiter; grants at most one operand pair per cycle.
- Product is registered into one output slot tagged with the requester id.
- Sits between HLS-generated loop bodies that each need a multiply, replacing per-loop multiplier instances.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DIN0_WIDTH, 8, signed operand A width.
- DIN1_WIDTH, 8, signed operand B width.
- DOUT_WIDTH, 8, result width; lower bits of the full signed product.
- ID_WIDTH, 2, requester-id width; must equal clog2(NUM_REQ).

Ports:
- ap_clk  in  1  clock; all state on rising edge.
- ap_rst_n  in  1  synchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero).
- req_din0  in  NUM_REQ*DIN0_WIDTH  packed operand A; requester i at bits [i*DIN0_WIDTH +: DIN0_WIDTH].
- req_din1  in  NUM_REQ*DIN1_WIDTH  packed operand B; same packing.
- out_valid  out  1  result slot full.
- out_ready  in  1  consumer accepts result.
- out_dout  out  DOUT_WIDTH  signed result.
- out_id  out  ID_WIDTH  index of the requester that produced the result.
- out_ovf  out  1  full product did not fit DOUT_WIDTH signed.

Behaviour:
- Reset (ap_rst_n=0 at a rising edge):
  - out_valid=0, out_dout=0, out_id=0, out_ovf=0.
  - rr_ptr=0.
  - req_ready is combinationally 0 while ap_rst_n=0.
  - An in-flight slot is discarded.
- Slot availability: `space = !out_valid || out_ready`.
- Arbitration:
  - Candidates are requesters with req_valid=1.
  - Search order rr_ptr, rr_ptr+1, ... mod NUM_REQ; the first hit wins.
  - req_ready[win] = space; all other req_ready bits = 0.
  - req_ready may depend combinationally on req_valid and out_ready.
- Accept (req_valid[i] && req_ready[i]):
  - Compute the full signed product, DIN0_WIDTH+DIN1_WIDTH bits.
  - Next cycle: out_valid=1, out_dout=result, out_id=i, out_ovf=overflow flag.
  - Next cycle: rr_ptr=(i+1) mod NUM_REQ.
- Latency is 1 cycle from accept to out_valid.
- Throughput is 1 result per cycle when out_ready is held at 1.
- No accept while out_valid=1 and out_ready=0: the slot holds out_dout, out_id and out_ovf stable; rr_ptr holds.
- Simultaneous pop and accept in one cycle: the slot is overwritten with the new result and out_valid stays 1.
- Pop with no accept: out_valid goes to 0.
- Width rules:
  - Result = product[DOUT_WIDTH-1:0] (truncation), two's complement.
  - out_ovf=1 iff product is outside [-2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1].
- Requester contract: hold req_valid, req_din0 and req_din1 stable until accepted. The block does not check this.
- Idle (no req_valid): rr_ptr unchanged; the slot drains normally.

Optional Feature:
- Macro: CASE_5_MUL_SHARE_SAT_EN.
- Defined: on overflow, out_dout saturates to 2^(DOUT_WIDTH-1)-1 (positive product) or -2^(DOUT_WIDTH-1) (negative product). out_ovf is still reported.
- Undefined: truncation as above. No saturation logic is synthesised.

Decomposition:
- Package case_5_mul_share_pkg:
  - Default constants NUM_REQ, DIN0_WIDTH, DIN1_WIDTH, DOUT_WIDTH.
  - Function clog2.
  - Typedef rsp_t {dout, id, ovf} for the output slot.
  - Localparams for saturation max/min.
- Sub-module case_5_mul_share_rr_grant:
  - Inputs: req vector, rr_ptr, enable.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational rotate/priority/rotate-back.
  - Unit-testable standalone.
- Multiply, overflow detect and slot register stay in the top.

Test Plan:
- Basic multiply: after reset, req_valid=4'b0001, din0=8'hFD (-3), din1=8'h05, out_ready=1 -> next cycle out_valid=1, out_dout=8'hF1, out_id=0, out_ovf=0.
- Overflow: req1 with 100 * 3 (full product 0x012C) -> out_dout=8'h2C, out_ovf=1. With CASE_5_MUL_SHARE_SAT_EN defined: 8'h7F, out_ovf=1.
- Negative corner: -128 * -128 (full product 0x4000) -> truncation gives 8'h00; SAT gives 8'h7F; out_ovf=1 in both builds.
- Round-robin: all 4 req_valid held high, out_ready=1 for 8 cycles -> out_id sequence 0,1,2,3,0,1,2,3 with no idle cycles. Then drop req2 -> sequence 0,1,3,0,1,3.
- Backpressure: out_valid=1, out_ready=0 for 5 cycles while all requesters are valid -> req_ready=0 and slot contents unchanged. On out_ready=1, pop and new accept occur in the same cycle and out_valid stays 1.
- Reset mid-operation: ap_rst_n=0 for one edge while out_valid=1, rr_ptr=2 -> out_valid=0, out_dout=0. The first grant after reset goes to requester 0 when all are valid.

Source files
------------

// File: rtl/case_5_mul_share_arb_pkg.sv
// Shared constants, slot type and helpers for the time-shared multiplier arbiter.
// Optional saturation is selected with CASE_5_MUL_SHARE_SAT_EN (see case_5_mul_share_arb).
package case_5_mul_share_pkg;

  localparam int unsigned NUM_REQ    = 4;
  localparam int unsigned DIN0_WIDTH = 8;
  localparam int unsigned DIN1_WIDTH = 8;
  localparam int unsigned DOUT_WIDTH = 8;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  localparam int unsigned ID_WIDTH = clog2(NUM_REQ);

  typedef struct packed {
    logic [DOUT_WIDTH-1:0] dout;
    logic [ID_WIDTH-1:0]   id;
    logic                  ovf;
  } rsp_t;

  localparam logic [DOUT_WIDTH-1:0] SAT_MAX = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic [DOUT_WIDTH-1:0] SAT_MIN = {1'b1, {(DOUT_WIDTH-1){1'b0}}};

endpackage

// File: rtl/case_5_mul_share_arb_if.sv
// Requester/result handshake bundle for case_5_mul_share_arb.
// slave is the arbiter side, master is the requester/consumer side.
interface case_5_mul_share_arb_if #(
  parameter int unsigned NUM_REQ    = case_5_mul_share_pkg::NUM_REQ,
  parameter int unsigned DIN0_WIDTH = case_5_mul_share_pkg::DIN0_WIDTH,
  parameter int unsigned DIN1_WIDTH = case_5_mul_share_pkg::DIN1_WIDTH,
  parameter int unsigned DOUT_WIDTH = case_5_mul_share_pkg::DOUT_WIDTH,
  parameter int unsigned ID_WIDTH   = case_5_mul_share_pkg::clog2(NUM_REQ)
) ();

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DIN0_WIDTH-1:0] req_din0;
  logic [NUM_REQ*DIN1_WIDTH-1:0] req_din1;
  logic                          out_valid;
  logic                          out_ready;
  logic [DOUT_WIDTH-1:0]         out_dout;
  logic [ID_WIDTH-1:0]           out_id;
  logic                          out_ovf;

  modport slave (
    input  req_valid, req_din0, req_din1, out_ready,
    output req_ready, out_valid, out_dout, out_id, out_ovf
  );

  modport master (
    output req_valid, req_din0, req_din1, out_ready,
    input  req_ready, out_valid, out_dout, out_id, out_ovf
  );

endinterface

// File: rtl/case_5_mul_share_rr_grant.sv
// Combinational round-robin grant: first requester at or after rr_ptr (wrapping) wins.
// gnt is one-hot and gated by enable; idx is the winner index whenever any req is set.
module case_5_mul_share_rr_grant #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ID_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] rr_ptr,
  input  logic                enable,
  output logic [NUM_REQ-1:0]  gnt,
  output logic [ID_WIDTH-1:0] idx
);
  import case_5_mul_share_pkg::*;

  logic                found;
  logic [31:0]         pos;
  logic [ID_WIDTH-1:0] pos_id;

  // Walking from rr_ptr in rotated order is the rotate/priority/rotate-back search unrolled.
  always_comb begin
    gnt    = '0;
    idx    = '0;
    found  = 1'b0;
    pos    = '0;
    pos_id = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos    = (32'(rr_ptr) + 32'(k)) % 32'(NUM_REQ);
      pos_id = pos[ID_WIDTH-1:0];
      if (!found && req[pos_id]) begin
        found       = 1'b1;
        idx         = pos_id;
        gnt[pos_id] = enable;
      end
    end
  end

endmodule

// File: rtl/case_5_mul_share_arb.sv
// One signed multiplier shared round-robin between NUM_REQ requesters, 1-cycle registered result.
// Define CASE_5_MUL_SHARE_SAT_EN to saturate overflowing results instead of truncating.
module case_5_mul_share_arb #(
  parameter int unsigned NUM_REQ    = case_5_mul_share_pkg::NUM_REQ,
  parameter int unsigned DIN0_WIDTH = case_5_mul_share_pkg::DIN0_WIDTH,
  parameter int unsigned DIN1_WIDTH = case_5_mul_share_pkg::DIN1_WIDTH,
  parameter int unsigned DOUT_WIDTH = case_5_mul_share_pkg::DOUT_WIDTH,
  parameter int unsigned ID_WIDTH   = case_5_mul_share_pkg::clog2(NUM_REQ)
) (
  input logic                   ap_clk,
  input logic                   ap_rst_n,
  case_5_mul_share_arb_if.slave bus
);
  import case_5_mul_share_pkg::*;

  localparam int unsigned PROD_WIDTH = DIN0_WIDTH + DIN1_WIDTH;

  typedef struct packed {
    logic [DOUT_WIDTH-1:0] dout;
    logic [ID_WIDTH-1:0]   id;
    logic                  ovf;
  } slot_t;

  slot_t                        slot_q, slot_d;
  logic                         valid_q;
  logic [ID_WIDTH-1:0]          rr_ptr_q, rr_ptr_d;
  logic                         space;
  logic                         grant_en;
  logic                         accept;
  logic [NUM_REQ-1:0]           gnt;
  logic [ID_WIDTH-1:0]          win;
  logic signed [DIN0_WIDTH-1:0] op_a;
  logic signed [DIN1_WIDTH-1:0] op_b;
  logic signed [PROD_WIDTH-1:0] prod;
  logic [PROD_WIDTH-DOUT_WIDTH:0] prod_hi;
  logic                         ovf;

  assign space    = !valid_q || bus.out_ready;
  assign grant_en = ap_rst_n && space;

  case_5_mul_share_rr_grant #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr_grant (
    .req    (bus.req_valid),
    .rr_ptr (rr_ptr_q),
    .enable (grant_en),
    .gnt    (gnt),
    .idx    (win)
  );

  assign bus.req_ready = gnt;
  assign accept        = |gnt;

  assign op_a = bus.req_din0[win*DIN0_WIDTH +: DIN0_WIDTH];
  assign op_b = bus.req_din1[win*DIN1_WIDTH +: DIN1_WIDTH];
  assign prod = op_a * op_b;

  // Fits iff every bit from the result sign bit upward equals the product sign.
  assign prod_hi = prod[PROD_WIDTH-1:DOUT_WIDTH-1];
  assign ovf     = !((&prod_hi) || !(|prod_hi));

  always_comb begin
    slot_d.id  = win;
    slot_d.ovf = ovf;
`ifdef CASE_5_MUL_SHARE_SAT_EN
    if (ovf) begin
      slot_d.dout = prod[PROD_WIDTH-1] ? {1'b1, {(DOUT_WIDTH-1){1'b0}}}
                                       : {1'b0, {(DOUT_WIDTH-1){1'b1}}};
    end else begin
      slot_d.dout = prod[DOUT_WIDTH-1:0];
    end
`else
    slot_d.dout = prod[DOUT_WIDTH-1:0];
`endif
  end

  assign rr_ptr_d = (win == ID_WIDTH'(NUM_REQ - 1)) ? '0 : win + 1'b1;

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      slot_q   <= '0;
      valid_q  <= 1'b0;
      rr_ptr_q <= '0;
    end else if (accept) begin
      slot_q   <= slot_d;
      valid_q  <= 1'b1;
      rr_ptr_q <= rr_ptr_d;
    end else if (bus.out_ready) begin
      valid_q  <= 1'b0;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_dout  = slot_q.dout;
  assign bus.out_id    = slot_q.id;
  assign bus.out_ovf   = slot_q.ovf;

endmodule

// File: tb/tb_case_5_mul_share_arb.sv
// Directed self-checking bench for case_5_mul_share_arb (default 4 requesters, 8x8->8).
module tb_case_5_mul_share_arb;
  import case_5_mul_share_pkg::*;

  logic ap_clk;
  logic ap_rst_n;
  int   checks;
  int   failures;

`ifdef CASE_5_MUL_SHARE_SAT_EN
  localparam logic [7:0] ExpOvfPos = SAT_MAX;
  localparam logic [7:0] ExpCorner = SAT_MAX;
  localparam logic [7:0] ExpOvfNeg = SAT_MIN;
`else
  localparam logic [7:0] ExpOvfPos = 8'h2C;
  localparam logic [7:0] ExpCorner = 8'h00;
  localparam logic [7:0] ExpOvfNeg = 8'hD4;
`endif

  case_5_mul_share_arb_if #(
    .NUM_REQ    (4),
    .DIN0_WIDTH (8),
    .DIN1_WIDTH (8),
    .DOUT_WIDTH (8),
    .ID_WIDTH   (2)
  ) bus ();

  case_5_mul_share_arb #(
    .NUM_REQ    (4),
    .DIN0_WIDTH (8),
    .DIN1_WIDTH (8),
    .DOUT_WIDTH (8),
    .ID_WIDTH   (2)
  ) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
    bus.req_din0[i*8 +: 8] = a;
    bus.req_din1[i*8 +: 8] = b;
  endtask

  task automatic check_slot(input string tag, input rsp_t exp);
    check({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, ".dout"},  32'(bus.out_dout),  32'(exp.dout));
    check({tag, ".id"},    32'(bus.out_id),    32'(exp.id));
    check({tag, ".ovf"},   32'(bus.out_ovf),   32'(exp.ovf));
  endtask

  rsp_t exp_rsp;
  int   seq_b [6] = '{0, 1, 3, 0, 1, 3};

  initial begin
    checks        = 0;
    failures      = 0;
    ap_rst_n      = 1'b0;
    bus.req_valid = 4'hF;
    bus.req_din0  = '0;
    bus.req_din1  = '0;
    bus.out_ready = 1'b0;

    // Reset state, and req_ready held low during reset even with all requesters valid
    tick();
    tick();
    check("rst.valid", 32'(bus.out_valid), 32'd0);
    check("rst.dout",  32'(bus.out_dout),  32'd0);
    check("rst.id",    32'(bus.out_id),    32'd0);
    check("rst.ovf",   32'(bus.out_ovf),   32'd0);
    check("rst.ready", 32'(bus.req_ready), 32'd0);

    // Basic: -3 * 5 = -15
    ap_rst_n      = 1'b1;
    bus.req_valid = 4'b0001;
    bus.out_ready = 1'b1;
    set_ops(0, 8'hFD, 8'h05);
    #1;
    check("basic.ready", 32'(bus.req_ready), 32'b0001);
    tick();
    bus.req_valid = 4'b0000;
    exp_rsp = '{dout: 8'hF1, id: 2'd0, ovf: 1'b0};
    check_slot("basic", exp_rsp);

    // Positive overflow: 100 * 3 = 0x012C
    bus.req_valid = 4'b0010;
    set_ops(1, 8'd100, 8'd3);
    #1;
    check("ovf.ready", 32'(bus.req_ready), 32'b0010);
    tick();
    bus.req_valid = 4'b0000;
    exp_rsp = '{dout: ExpOvfPos, id: 2'd1, ovf: 1'b1};
    check_slot("ovfpos", exp_rsp);

    // Corner: -128 * -128 = 0x4000
    bus.req_valid = 4'b0100;
    set_ops(2, 8'h80, 8'h80);
    tick();
    bus.req_valid = 4'b0000;
    exp_rsp = '{dout: ExpCorner, id: 2'd2, ovf: 1'b1};
    check_slot("corner", exp_rsp);

    // Negative overflow: -100 * 3 = -300 = 0xFED4
    bus.req_valid = 4'b1000;
    set_ops(3, 8'h9C, 8'd3);
    tick();
    bus.req_valid = 4'b0000;
    exp_rsp = '{dout: ExpOvfNeg, id: 2'd3, ovf: 1'b1};
    check_slot("ovfneg", exp_rsp);

    // Pop with no accept empties the slot
    tick();
    check("drain.valid", 32'(bus.out_valid), 32'd0);

    // Round robin with all valid: operand i gives (i+1)*2; pointer wrapped to 0
    for (int i = 0; i < 4; i++) set_ops(i, 8'(i + 1), 8'd2);
    bus.req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      tick();
      exp_rsp = '{dout: 8'(((k % 4) + 1) * 2), id: 2'(k % 4), ovf: 1'b0};
      check_slot($sformatf("rr4[%0d]", k), exp_rsp);
    end

    // Drop requester 2
    bus.req_valid = 4'b1011;
    for (int k = 0; k < 6; k++) begin
      tick();
      exp_rsp = '{dout: 8'((seq_b[k] + 1) * 2), id: 2'(seq_b[k]), ovf: 1'b0};
      check_slot($sformatf("rr3[%0d]", k), exp_rsp);
    end

    // Backpressure: slot holds id 3 / dout 8 while consumer stalls
    bus.req_valid = 4'hF;
    bus.out_ready = 1'b0;
    #1;
    check("bp.ready0", 32'(bus.req_ready), 32'd0);
    exp_rsp = '{dout: 8'd8, id: 2'd3, ovf: 1'b0};
    for (int k = 0; k < 5; k++) begin
      tick();
      check_slot($sformatf("bp[%0d]", k), exp_rsp);
      check($sformatf("bp[%0d].ready", k), 32'(bus.req_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp.release_ready", 32'(bus.req_ready), 32'b0001);
    tick();
    exp_rsp = '{dout: 8'd2, id: 2'd0, ovf: 1'b0};
    check_slot("bp.popaccept", exp_rsp);
    tick();
    exp_rsp = '{dout: 8'd4, id: 2'd1, ovf: 1'b0};
    check_slot("pre_rst", exp_rsp);

    // Reset mid-operation with out_valid=1 and rr_ptr=2
    bus.out_ready = 1'b0;
    ap_rst_n      = 1'b0;
    tick();
    check("mrst.valid", 32'(bus.out_valid), 32'd0);
    check("mrst.dout",  32'(bus.out_dout),  32'd0);
    check("mrst.id",    32'(bus.out_id),    32'd0);
    ap_rst_n      = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check("mrst.ready", 32'(bus.req_ready), 32'b0001);
    tick();
    exp_rsp = '{dout: 8'd2, id: 2'd0, ovf: 1'b0};
    check_slot("mrst.first", exp_rsp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
